// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: states, opcodes, ALU ops, immediate formats, faults.
package riscv_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // funct3 -> ALU op, shared by R-type and I-ALU (sub is resolved by funct7)
    function automatic logic [3:0] f3_alu_op(input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = ALU_ADD;
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic f3_alu_legal(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
               (f3 == F3_OR)  || (f3 == F3_AND);
    endfunction

endpackage

// File: rtl/riscv_ctrl_if.sv
// Control-unit <-> datapath/memory bundle; master is the control FSM, slave is the datapath side.
interface riscv_ctrl_if;
    logic [31:0] instruction;
    logic        zero;
    logic        negative;
    logic        mem_ready;
    logic        ALUsrc;
    logic [1:0]  imm_src;
    logic [3:0]  Operation;
    logic        we;
    logic        re;
    logic        MemtoReg;
    logic        rg_wrt_en;
    logic        pc_en;
    logic        pc_src;
    logic [2:0]  state;
    logic [1:0]  fault_code;

    modport master (
        input  instruction, zero, negative, mem_ready,
        output ALUsrc, imm_src, Operation, we, re, MemtoReg,
               rg_wrt_en, pc_en, pc_src, state, fault_code
    );

    modport slave (
        output instruction, zero, negative, mem_ready,
        input  ALUsrc, imm_src, Operation, we, re, MemtoReg,
               rg_wrt_en, pc_en, pc_src, state, fault_code
    );
endinterface

// File: rtl/riscv_alu_decoder.sv
// Opcode/funct3/funct7 -> ALU Operation plus legality flag.
// CTRL_BRANCH_EXT_EN additionally accepts BNE and BLT on the branch opcode.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] operation,
    output logic       legal
);

    always_comb begin
        operation = ALU_ADD;
        legal     = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                operation = f3_alu_op(funct3);
                legal     = f3_alu_legal(funct3) && (funct7 == F7_BASE);
                if ((funct3 == F3_ADD) && (funct7 == F7_ALT)) begin
                    operation = ALU_SUB;
                    legal     = 1'b1;
                end
            end
            OPC_IALU: begin
                operation = f3_alu_op(funct3);
                legal     = f3_alu_legal(funct3);
            end
            OPC_LOAD, OPC_STORE: begin
                operation = ALU_ADD;
                legal     = (funct3 == F3_WORD);
            end
            OPC_BRANCH: begin
                operation = ALU_SUB;
`ifdef CTRL_BRANCH_EXT_EN
                legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE) || (funct3 == F3_BLT);
`else
                legal = (funct3 == F3_BEQ);
`endif
            end
            default: begin
                operation = ALU_ADD;
                legal     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-wait timeout and illegal-instruction trap.
// CTRL_BRANCH_EXT_EN enables BNE/BLT branch resolution.
module riscv_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_IR     = 32'h00000013,
    parameter int unsigned MEM_WAIT_MAX = 15
)
(
    input  logic        clk,
    input  logic        reset,
    riscv_ctrl_if.master bus
);

    localparam int unsigned CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [31:0]   ir;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    fault_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_op;
    logic       legal;
    logic       is_ialu;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       taken;
    logic       mem_timeout;
    logic       unused_bits;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign funct7  = ir[31:25];
    assign is_ialu = (opcode == OPC_IALU);
    assign is_lw   = (opcode == OPC_LOAD);
    assign is_sw   = (opcode == OPC_STORE);
    assign is_br   = (opcode == OPC_BRANCH);

    // Register indices belong to the datapath; only opcode/funct fields steer control.
    assign unused_bits = ^{ir[24:15], ir[11:7], bus.negative};

    riscv_alu_decoder u_alu_dec (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .operation (alu_op),
        .legal     (legal)
    );

    always_comb begin
        taken = 1'b0;
        if (is_br) begin
            case (funct3)
                F3_BEQ:  taken = bus.zero;
`ifdef CTRL_BRANCH_EXT_EN
                F3_BNE:  taken = ~bus.zero;
                F3_BLT:  taken = bus.negative;
`endif
                default: taken = 1'b0;
            endcase
        end
    end

    // Trap on the MEM_WAIT_MAX-th consecutive not-ready cycle; ready on that cycle still wins.
    assign mem_timeout = !bus.mem_ready && (wait_cnt == CW'(MEM_WAIT_MAX - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                if (is_br)
                    state_d = ST_FETCH;
                else if (is_lw || is_sw)
                    state_d = ST_MEM;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (bus.mem_ready)
                    state_d = is_lw ? ST_WB : ST_FETCH;
                else if (mem_timeout)
                    state_d = ST_TRAP;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            ir       <= RESET_IR;
            wait_cnt <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH)
                ir <= bus.instruction;
            if (state_q == ST_EXEC)
                wait_cnt <= '0;
            else if ((state_q == ST_MEM) && !bus.mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
            if ((state_q == ST_DECODE) && !legal)
                fault_q <= FAULT_ILLEGAL;
            else if ((state_q == ST_MEM) && (state_d == ST_TRAP))
                fault_q <= FAULT_TIMEOUT;
        end
    end

    always_comb begin
        bus.imm_src = IMM_I;
        if (is_sw)
            bus.imm_src = IMM_S;
        else if (is_br)
            bus.imm_src = IMM_B;
    end

    assign bus.ALUsrc     = is_ialu || is_lw || is_sw;
    assign bus.Operation  = alu_op;
    assign bus.MemtoReg   = is_lw;
    assign bus.re         = (state_q == ST_MEM) && is_lw;
    assign bus.we         = (state_q == ST_MEM) && is_sw;
    assign bus.rg_wrt_en  = (state_q == ST_WB);
    assign bus.pc_en      = (state_q == ST_WB) ||
                            ((state_q == ST_EXEC) && is_br) ||
                            ((state_q == ST_MEM) && is_sw && bus.mem_ready);
    assign bus.pc_src     = (state_q == ST_EXEC) && is_br && taken;
    assign bus.state      = state_q;
    assign bus.fault_code = fault_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Scoreboard bench for riscv_ctrl_fsm: per-cycle expected control outputs are queued as stimulus is driven.
// Branch expectations follow CTRL_BRANCH_EXT_EN when it is defined.
module tb_riscv_ctrl_fsm;

    localparam int WAIT_MAX = 15;
    localparam int C_ALU = 0;
    localparam int C_LW  = 1;
    localparam int C_SW  = 2;
    localparam int C_BR  = 3;
    localparam int C_ILL = 4;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [31:0] I_LW  = 32'h00802283;
    localparam logic [31:0] I_SW  = 32'h00502623;
    localparam logic [31:0] I_BEQ = 32'h00000463;
    localparam logic [31:0] I_ADD = 32'h002081B3;

    typedef struct {
        logic [2:0] st;
        logic       re;
        logic       we;
        logic       rg;
        logic       pe;
        logic       ps;
        logic [1:0] fc;
        logic       dec;
        logic [3:0] op;
        logic       asrc;
        int         imm;
        logic       m2r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_fault;

    riscv_ctrl_if bus ();

    riscv_ctrl_fsm #(
        .RESET_IR     (32'h00000013),
        .MEM_WAIT_MAX (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic re, input logic we,
                                input logic rg, input logic pe, input logic ps);
        exp_t e;
        e.st = st; e.re = re; e.we = we; e.rg = rg; e.pe = pe; e.ps = ps;
        e.fc = exp_fault; e.dec = 1'b0; e.op = 4'h0; e.asrc = 1'b0; e.imm = -1; e.m2r = 1'b0;
        return e;
    endfunction

    function automatic exp_t add_dec(input exp_t e, input logic [3:0] op, input logic asrc,
                                     input int imm, input logic m2r);
        exp_t r;
        r = e; r.dec = 1'b1; r.op = op; r.asrc = asrc; r.imm = imm; r.m2r = m2r;
        return r;
    endfunction

    // Drive one cycle's inputs, queue its expectation, compare mid-cycle, advance past the next edge.
    task automatic cyc(input logic mr, input logic z, input logic ng, input exp_t e);
        exp_t x;
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.negative  = ng;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        check("state",      32'(bus.state),      32'(x.st));
        check("re",         32'(bus.re),         32'(x.re));
        check("we",         32'(bus.we),         32'(x.we));
        check("rg_wrt_en",  32'(bus.rg_wrt_en),  32'(x.rg));
        check("pc_en",      32'(bus.pc_en),      32'(x.pe));
        check("pc_src",     32'(bus.pc_src),     32'(x.ps));
        check("fault_code", 32'(bus.fault_code), 32'(x.fc));
        if (x.dec) begin
            check("Operation", 32'(bus.Operation), 32'(x.op));
            check("ALUsrc",    32'(bus.ALUsrc),    32'(x.asrc));
            check("MemtoReg",  32'(bus.MemtoReg),  32'(x.m2r));
            if (x.imm >= 0)
                check("imm_src", 32'(bus.imm_src), 32'(x.imm));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        exp_fault = 2'b00;
        cyc(1'b1, 1'b0, 1'b0, mk(S_FETCH, 0, 0, 0, 0, 0));
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int cls, input logic [3:0] op,
                             input logic asrc, input int imm, input logic m2r, input int waits,
                             input logic z, input logic ng, input logic tk, input int ntrap);
        logic lw;
        logic sw;
        lw = (cls == C_LW);
        sw = (cls == C_SW);
        bus.instruction = ins;
        cyc(1'b1, z, ng, mk(S_FETCH, 0, 0, 0, 0, 0));
        if (cls == C_ILL) begin
            cyc(1'b1, z, ng, mk(S_DECODE, 0, 0, 0, 0, 0));
            exp_fault = 2'b01;
            repeat (ntrap) cyc(1'b1, z, ng, mk(S_TRAP, 0, 0, 0, 0, 0));
            return;
        end
        cyc(1'b1, z, ng, add_dec(mk(S_DECODE, 0, 0, 0, 0, 0), op, asrc, imm, m2r));
        cyc(1'b1, z, ng, add_dec(mk(S_EXEC, 0, 0, 0, cls == C_BR, (cls == C_BR) && tk),
                                 op, asrc, imm, m2r));
        if (cls == C_ALU) begin
            cyc(1'b1, z, ng, add_dec(mk(S_WB, 0, 0, 1, 1, 0), op, asrc, imm, m2r));
        end else if (lw || sw) begin
            for (int i = 0; i < waits && i < WAIT_MAX; i++)
                cyc(1'b0, z, ng, add_dec(mk(S_MEM, lw, sw, 0, 0, 0), op, asrc, imm, m2r));
            if (waits >= WAIT_MAX) begin
                exp_fault = 2'b10;
                repeat (ntrap) cyc(1'b0, z, ng, mk(S_TRAP, 0, 0, 0, 0, 0));
            end else begin
                cyc(1'b1, z, ng, add_dec(mk(S_MEM, lw, sw, 0, sw, 0), op, asrc, imm, m2r));
                if (lw)
                    cyc(1'b1, z, ng, add_dec(mk(S_WB, 0, 0, 1, 1, 0), op, asrc, imm, m2r));
            end
        end
    endtask

    logic [31:0] alu_ins [11] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                  32'h0020C1B3, 32'h0020A1B3, 32'h00500093, 32'h0050F093,
                                  32'h0050E093, 32'h0050C093, 32'h0050A093};
    logic [3:0]  alu_exp [11] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                  4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    logic        alu_src [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        reset           = 1'b1;
        exp_fault       = 2'b00;
        bus.instruction = 32'h0;
        bus.zero        = 1'b0;
        bus.negative    = 1'b0;
        bus.mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 11; i++)
            run_instr(alu_ins[i], C_ALU, alu_exp[i], alu_src[i], alu_src[i] ? 0 : -1,
                      1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        run_instr(I_LW, C_LW, 4'b0010, 1'b1, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_LW, C_LW, 4'b0010, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_LW, C_LW, 4'b0010, 1'b1, 0, 1'b1, WAIT_MAX - 1, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_SW, C_SW, 4'b0010, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_SW, C_SW, 4'b0010, 1'b1, 1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_SW, C_SW, 4'b0010, 1'b1, 1, 1'b0, WAIT_MAX - 1, 1'b0, 1'b0, 1'b0, 0);

        run_instr(I_BEQ, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b1, 1'b0, 1'b1, 0);
        run_instr(I_BEQ, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_instr(I_BEQ, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0);

`ifdef CTRL_BRANCH_EXT_EN
        run_instr(32'h00001463, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
        run_instr(32'h00001463, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        run_instr(32'h00004463, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0);
        run_instr(32'h00004463, C_BR, 4'b0110, 1'b0, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
`else
        run_instr(32'h00001463, C_ILL, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
        do_reset();
        run_instr(32'h00004463, C_ILL, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 3);
        do_reset();
`endif

        run_instr(32'h202081B3, C_ILL, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
        do_reset();
        run_instr(32'h002091B3, C_ILL, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
        do_reset();

        run_instr(32'hFFFFFFFF, C_ILL, 4'h0, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 20);
        do_reset();
        run_instr(I_ADD, C_ALU, 4'b0010, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        run_instr(I_LW, C_LW, 4'b0010, 1'b1, 0, 1'b1, WAIT_MAX, 1'b0, 1'b0, 1'b0, 5);
        do_reset();
        run_instr(I_ADD, C_ALU, 4'b0010, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        // Reset asserted between edges while a load is waiting in MEM.
        bus.instruction = I_LW;
        cyc(1'b0, 1'b0, 1'b0, mk(S_FETCH, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b0, 1'b0, mk(S_DECODE, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b0, 1'b0, mk(S_EXEC, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b0, 1'b0, mk(S_MEM, 1, 0, 0, 0, 0));
        cyc(1'b0, 1'b0, 1'b0, mk(S_MEM, 1, 0, 0, 0, 0));
        #2;
        check("mid_re_before", 32'(bus.re), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_re",        32'(bus.re),        32'd0);
        check("mid_state",     32'(bus.state),     32'(S_FETCH));
        check("mid_rg_wrt_en", 32'(bus.rg_wrt_en), 32'd0);
        check("mid_pc_en",     32'(bus.pc_en),     32'd0);
        @(posedge clk);
        #1;
        do_reset();
        run_instr(I_ADD, C_ALU, 4'b0010, 1'b0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion before t=200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit reached");
    end

endmodule
